// File: rtl/md_pkg.sv
// Shared types and constants for the Execute stage with RV32M/RV64M multiply/divide.
// Opcode encodings follow funct3 for M ops and the existing ALUControlE/BranchTypeE codes.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_AND   = 2;
    localparam int ALU_OR    = 3;
    localparam int ALU_XOR   = 4;
    localparam int ALU_SLT   = 5;
    localparam int ALU_SLTU  = 6;
    localparam int ALU_SLL   = 7;
    localparam int ALU_SRL   = 8;
    localparam int ALU_SRA   = 9;
    localparam int ALU_PASSB = 10;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Special-case constants are built 64 bits wide and sliced to XLEN by the user.
    function automatic logic [63:0] md_int_min(input int xlen);
        md_int_min = 64'h1 << (xlen - 1);
    endfunction

    function automatic logic [63:0] md_all_ones(input int xlen);
        md_all_ones = (xlen >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << xlen) - 64'h1);
    endfunction

endpackage

// File: rtl/execute_stage_md_md_unit.sv
// Multi-cycle multiply/divide unit: IDLE/RUN/DONE FSM with a shared radix-2
// shift-add / restoring-divide datapath, plus the single-cycle multiply path.
module md_unit
    import md_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MUL_ITERATIVE = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [63:0] ONES_W = md_all_ones(XLEN);
    localparam logic [63:0] MIN_W  = md_int_min(XLEN);
    localparam logic [XLEN-1:0] ALL_ONES = ONES_W[XLEN-1:0];
    localparam logic [XLEN-1:0] INT_MIN  = MIN_W[XLEN-1:0];

    md_state_t       state;
    md_op_t          op_q;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] acc, quot, bm;
    logic            neg_q, neg_r;

    md_op_t                 op_i;
    logic                   a_sgn, b_sgn, a_neg, b_neg, is_div, div0, ovf, comb_op, accept;
    logic [XLEN-1:0]        a_mag, b_mag;
    logic [XLEN:0]          mul_sum, div_sh;
    logic [XLEN-1:0]        div_sub, acc_n, quot_n, comb_res;
    logic                   div_ge;
    logic signed [2*XLEN-1:0] mp;

    // Sign fixup on the magnitude result: hi holds product-high / remainder, lo holds product-low / quotient.
    function automatic logic [XLEN-1:0] md_fixup(input md_op_t o, input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo, input logic nq, input logic nr);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   q, r;
        prod = nq ? -{hi, lo} : {hi, lo};
        q    = nq ? -lo : lo;
        r    = nr ? -hi : hi;
        case (o)
            MD_MUL:                       md_fixup = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: md_fixup = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              md_fixup = q;
            default:                      md_fixup = r;
        endcase
    endfunction

    always_comb begin
        op_i    = md_op_t'(op);
        is_div  = op[2];
        a_sgn   = (op_i == MD_MULH) || (op_i == MD_MULHSU) || (op_i == MD_DIV) || (op_i == MD_REM);
        b_sgn   = (op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM);
        a_neg   = a_sgn & a[XLEN-1];
        b_neg   = b_sgn & b[XLEN-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        div0    = is_div & (b == '0);
        ovf     = is_div & b_sgn & (a == INT_MIN) & (b == ALL_ONES);
        comb_op = (MUL_ITERATIVE == 0) & ~is_div;
        accept  = (state == IDLE) & start & ~flush & ~comb_op;
    end

    // One radix-2 step; op_q[2] distinguishes divide from multiply.
    always_comb begin
        mul_sum = {1'b0, acc} + (quot[0] ? {1'b0, bm} : '0);
        div_sh  = {acc, quot[XLEN-1]};
        div_ge  = div_sh >= {1'b0, bm};
        div_sub = div_sh[XLEN-1:0] - bm;
        if (op_q[2]) begin
            acc_n  = div_ge ? div_sub : div_sh[XLEN-1:0];
            quot_n = {quot[XLEN-2:0], div_ge};
        end else begin
            acc_n  = mul_sum[XLEN:1];
            quot_n = {mul_sum[0], quot[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= MD_MUL;
            count <= '0;
            acc   <= '0;
            quot  <= '0;
            bm    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q  <= op_i;
                    bm    <= is_div ? b_mag : a_mag;
                    count <= CW'(XLEN);
                    if (div0) begin
                        quot  <= ALL_ONES;
                        acc   <= a;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= DONE;
                    end else if (ovf) begin
                        quot  <= a;
                        acc   <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= DONE;
                    end else begin
                        quot  <= is_div ? a_mag : b_mag;
                        acc   <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_n;
                    quot  <= quot_n;
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Single-cycle multiply: sign-extend each operand to 2*XLEN; the low 2*XLEN product bits are exact.
    always_comb begin
        mp       = $signed({{XLEN{a_neg}}, a}) * $signed({{XLEN{b_neg}}, b});
        comb_res = (op_i == MD_MUL) ? mp[XLEN-1:0] : mp[2*XLEN-1:XLEN];
    end

    assign done   = (state == DONE);
    assign busy   = ~reset & ((state == RUN) | accept);
    assign result = done ? md_fixup(op_q, acc, quot, neg_q, neg_r) : comb_res;

endmodule

// File: rtl/execute_stage_md.sv
// RISC-V Execute stage: forwarding, ALU, branch/jump target, and the M-extension unit
// whose StallMDE output freezes the front of the pipeline while an op iterates.
module execute_stage_md
    import md_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MUL_ITERATIVE = 0,
    parameter int ALU_OPW       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushE,
    input  logic               JumpE,
    input  logic               BranchE,
    input  logic               ALUSrcE,
    input  logic               JalrE,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    input  logic [ALU_OPW-1:0] ALUControlE,
    input  logic [2:0]         BranchTypeE,
    input  logic               MdE,
    input  logic [2:0]         MdOpE,
    input  logic [XLEN-1:0]    PCE,
    input  logic [XLEN-1:0]    ExtImmE,
    input  logic [XLEN-1:0]    RD1E,
    input  logic [XLEN-1:0]    RD2E,
    input  logic [XLEN-1:0]    ALUResultM,
    input  logic [XLEN-1:0]    ResultW,
    output logic [XLEN-1:0]    ALUResultE,
    output logic [XLEN-1:0]    WriteDataE,
    output logic [XLEN-1:0]    PCTargetE,
    output logic               PCSrcE,
    output logic               StallMDE
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] SrcAE, SrcBE, alu_result, md_result;
    logic [SHW-1:0]  shamt;
    logic            br_eq, br_lt, br_ltu, br_taken, md_done, md_comb;

    always_comb begin
        case (ForwardAE)
            2'b01:   SrcAE = ResultW;
            2'b10:   SrcAE = ALUResultM;
            default: SrcAE = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   WriteDataE = ResultW;
            2'b10:   WriteDataE = ALUResultM;
            default: WriteDataE = RD2E;
        endcase
        SrcBE = ALUSrcE ? ExtImmE : WriteDataE;
        shamt = SrcBE[SHW-1:0];
    end

    always_comb begin
        case (int'(ALUControlE))
            ALU_ADD:   alu_result = SrcAE + SrcBE;
            ALU_SUB:   alu_result = SrcAE - SrcBE;
            ALU_AND:   alu_result = SrcAE & SrcBE;
            ALU_OR:    alu_result = SrcAE | SrcBE;
            ALU_XOR:   alu_result = SrcAE ^ SrcBE;
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(SrcAE) < $signed(SrcBE)};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, SrcAE < SrcBE};
            ALU_SLL:   alu_result = SrcAE << shamt;
            ALU_SRL:   alu_result = SrcAE >> shamt;
            ALU_SRA:   alu_result = $signed(SrcAE) >>> shamt;
            ALU_PASSB: alu_result = SrcBE;
            default:   alu_result = '0;
        endcase
    end

    // Branches compare the forwarded register operands, never the immediate.
    always_comb begin
        br_eq  = (SrcAE == WriteDataE);
        br_lt  = ($signed(SrcAE) < $signed(WriteDataE));
        br_ltu = (SrcAE < WriteDataE);
        case (BranchTypeE)
            BR_BEQ:  br_taken = br_eq;
            BR_BNE:  br_taken = ~br_eq;
            BR_BLT:  br_taken = br_lt;
            BR_BGE:  br_taken = ~br_lt;
            BR_BLTU: br_taken = br_ltu;
            BR_BGEU: br_taken = ~br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    assign PCTargetE = (JalrE ? RD1E : PCE) + ExtImmE;
    assign PCSrcE    = (br_taken & BranchE) | JumpE;

    md_unit #(
        .XLEN          (XLEN),
        .MUL_ITERATIVE (MUL_ITERATIVE)
    ) u_md (
        .clk    (clk),
        .reset  (reset),
        .flush  (FlushE),
        .start  (MdE),
        .op     (MdOpE),
        .a      (SrcAE),
        .b      (WriteDataE),
        .result (md_result),
        .busy   (StallMDE),
        .done   (md_done)
    );

    assign md_comb    = MdE & (MUL_ITERATIVE == 0) & ~MdOpE[2];
    assign ALUResultE = (MdE & (md_done | md_comb)) ? md_result : alu_result;

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md: one instance with single-cycle multiply, one iterative.
module tb_execute_stage_md;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset, FlushE, JumpE, BranchE, ALUSrcE, JalrE, MdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [3:0]  ALUControlE;
    logic [2:0]  BranchTypeE, MdOpE;
    logic [31:0] PCE, ExtImmE, RD1E, RD2E, ALUResultM, ResultW;
    logic [31:0] alu0, wd0, pct0, alu1, wd1, pct1;
    logic        pcs0, pcs1, stall0, stall1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_stage_md #(.XLEN(32), .MUL_ITERATIVE(0), .ALU_OPW(4)) dut0 (
        .clk(clk), .reset(reset), .FlushE(FlushE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .JalrE(JalrE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUControlE(ALUControlE), .BranchTypeE(BranchTypeE), .MdE(MdE), .MdOpE(MdOpE),
        .PCE(PCE), .ExtImmE(ExtImmE), .RD1E(RD1E), .RD2E(RD2E), .ALUResultM(ALUResultM),
        .ResultW(ResultW), .ALUResultE(alu0), .WriteDataE(wd0), .PCTargetE(pct0),
        .PCSrcE(pcs0), .StallMDE(stall0));

    execute_stage_md #(.XLEN(32), .MUL_ITERATIVE(1), .ALU_OPW(4)) dut1 (
        .clk(clk), .reset(reset), .FlushE(FlushE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .JalrE(JalrE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUControlE(ALUControlE), .BranchTypeE(BranchTypeE), .MdE(MdE), .MdOpE(MdOpE),
        .PCE(PCE), .ExtImmE(ExtImmE), .RD1E(RD1E), .RD2E(RD2E), .ALUResultM(ALUResultM),
        .ResultW(ResultW), .ALUResultE(alu1), .WriteDataE(wd1), .PCTargetE(pct1),
        .PCSrcE(pcs1), .StallMDE(stall1));

    // Issue one M op, hold it while stalled, and record stall cycles and the result of each instance.
    task automatic md_op(input logic [2:0] op, input logic [1:0] fa, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] m,
                         output int st0, output int st1, output logic [31:0] r0,
                         output logic [31:0] r1, output bit to);
        bit d0, d1;
        @(posedge clk); #1;
        MdE = 1'b1; MdOpE = op; ForwardAE = fa; ForwardBE = 2'b00; ALUSrcE = 1'b0;
        RD1E = a; RD2E = b; ALUResultM = m;
        st0 = 0; st1 = 0; d0 = 1'b0; d1 = 1'b0; r0 = 'x; r1 = 'x;
        for (int i = 0; i < 200 && !(d0 && d1); i++) begin
            @(negedge clk);
            if (!d0) begin
                if (stall0) st0++;
                else begin r0 = alu0; d0 = 1'b1; end
            end
            if (!d1) begin
                if (stall1) st1++;
                else begin r1 = alu1; d1 = 1'b1; end
            end
            if (i > 0) ALUResultM = ALUResultM ^ 32'h5A5A_5A5A;
        end
        to = !(d0 && d1);
        @(posedge clk); #1;
        MdE = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; FlushE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0; JalrE = 0;
        ForwardAE = 0; ForwardBE = 0; ALUControlE = 4'd0; BranchTypeE = 3'b000;
        MdE = 1'b1; MdOpE = MD_DIV; PCE = 0; ExtImmE = 0; RD1E = 32'd5; RD2E = 32'd7;
        ALUResultM = 0; ResultW = 0;
        #2;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL reset_stall0 got %b exp 0", stall0); end
        checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL reset_stall1 got %b exp 0", stall1); end
        checks++; if (alu0 !== 32'd12) begin errors++; $display("FAIL reset_alu got %h exp %h", alu0, 32'd12); end
        checks++; if (dut0.u_md.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dut0.u_md.state); end
        MdE = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        @(posedge clk); #1;
        ALUControlE = 4'd0; RD1E = 32'd5; RD2E = 32'd7; @(negedge clk);
        checks++; if (alu0 !== 32'd12) begin errors++; $display("FAIL alu_add got %h exp %h", alu0, 32'd12); end
        ALUControlE = 4'd1; RD1E = 32'd10; ForwardBE = 2'b01; ResultW = 32'd3; #1;
        checks++; if (alu0 !== 32'd7) begin errors++; $display("FAIL alu_sub_fwd got %h exp %h", alu0, 32'd7); end
        checks++; if (wd0 !== 32'd3) begin errors++; $display("FAIL writedata_fwd got %h exp %h", wd0, 32'd3); end
        ALUControlE = 4'd0; ALUSrcE = 1'b1; ExtImmE = 32'h10; ForwardBE = 2'b00; #1;
        checks++; if (alu0 !== 32'h1A) begin errors++; $display("FAIL alu_imm got %h exp %h", alu0, 32'h1A); end
        ALUControlE = 4'd5; ALUSrcE = 1'b0; RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; #1;
        checks++; if (alu0 !== 32'd1) begin errors++; $display("FAIL alu_slt got %h exp %h", alu0, 32'd1); end
        PCE = 32'h100; ExtImmE = 32'h10; JalrE = 1'b0; #1;
        checks++; if (pct0 !== 32'h110) begin errors++; $display("FAIL pctarget got %h exp %h", pct0, 32'h110); end
        JalrE = 1'b1; RD1E = 32'h40; #1;
        checks++; if (pct0 !== 32'h50) begin errors++; $display("FAIL pctarget_jalr got %h exp %h", pct0, 32'h50); end
        JalrE = 1'b0; RD1E = 32'd4; RD2E = 32'd4; BranchE = 1'b1; BranchTypeE = 3'b000; #1;
        checks++; if (pcs0 !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", pcs0); end
        BranchTypeE = 3'b001; #1;
        checks++; if (pcs0 !== 1'b0) begin errors++; $display("FAIL bne_not_taken got %b exp 0", pcs0); end
        BranchE = 1'b0; JumpE = 1'b1; #1;
        checks++; if (pcs0 !== 1'b1) begin errors++; $display("FAIL jump got %b exp 1", pcs0); end
        JumpE = 1'b0; ALUControlE = 4'd0;
    endtask

    task automatic test_div();
        int s0, s1; logic [31:0] r0, r1; bit to;
        md_op(MD_DIV, 2'b00, 32'hFFFF_FFEC, 32'd3, 32'd0, s0, s1, r0, r1, to);
        checks++; if (to) begin errors++; $display("FAIL div_timeout got timeout exp completion"); end
        checks++; if (s0 !== 33) begin errors++; $display("FAIL div_stalls got %0d exp 33", s0); end
        checks++; if (r0 !== 32'hFFFF_FFFA) begin errors++; $display("FAIL div_result got %h exp %h", r0, 32'hFFFF_FFFA); end
        md_op(MD_REM, 2'b00, 32'hFFFF_FFEC, 32'd3, 32'd0, s0, s1, r0, r1, to);
        checks++; if (s0 !== 33) begin errors++; $display("FAIL rem_stalls got %0d exp 33", s0); end
        checks++; if (r0 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rem_result got %h exp %h", r0, 32'hFFFF_FFFE); end
        md_op(MD_REMU, 2'b00, 32'd20, 32'd3, 32'd0, s0, s1, r0, r1, to);
        checks++; if (r0 !== 32'd2) begin errors++; $display("FAIL remu_result got %h exp %h", r0, 32'd2); end
        md_op(MD_DIVU, 2'b00, 32'd1000, 32'd7, 32'd0, s0, s1, r0, r1, to);
        checks++; if (r1 !== 32'd142) begin errors++; $display("FAIL divu_result got %h exp %h", r1, 32'd142); end
    endtask

    task automatic test_div_special();
        int s0, s1; logic [31:0] r0, r1; bit to;
        md_op(MD_DIVU, 2'b00, 32'd7, 32'd0, 32'd0, s0, s1, r0, r1, to);
        checks++; if (s0 !== 1) begin errors++; $display("FAIL divu0_stalls got %0d exp 1", s0); end
        checks++; if (r0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_result got %h exp %h", r0, 32'hFFFF_FFFF); end
        md_op(MD_REMU, 2'b00, 32'd7, 32'd0, 32'd0, s0, s1, r0, r1, to);
        checks++; if (r0 !== 32'd7) begin errors++; $display("FAIL remu0_result got %h exp %h", r0, 32'd7); end
        md_op(MD_DIV, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, s0, s1, r0, r1, to);
        checks++; if (s0 !== 1) begin errors++; $display("FAIL divovf_stalls got %0d exp 1", s0); end
        checks++; if (r0 !== 32'h8000_0000) begin errors++; $display("FAIL divovf_result got %h exp %h", r0, 32'h8000_0000); end
        md_op(MD_REM, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, s0, s1, r0, r1, to);
        checks++; if (r0 !== 32'd0) begin errors++; $display("FAIL removf_result got %h exp %h", r0, 32'd0); end
    endtask

    task automatic test_mul();
        int s0, s1; logic [31:0] r0, r1; bit to;
        md_op(MD_MULH, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'd0, s0, s1, r0, r1, to);
        checks++; if (s0 !== 0) begin errors++; $display("FAIL mulh_comb_stalls got %0d exp 0", s0); end
        checks++; if (r0 !== 32'h4000_0000) begin errors++; $display("FAIL mulh_comb got %h exp %h", r0, 32'h4000_0000); end
        checks++; if (s1 !== 33) begin errors++; $display("FAIL mulh_iter_stalls got %0d exp 33", s1); end
        checks++; if (r1 !== 32'h4000_0000) begin errors++; $display("FAIL mulh_iter got %h exp %h", r1, 32'h4000_0000); end
        md_op(MD_MULHU, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0, s0, s1, r0, r1, to);
        checks++; if (r0 !== 32'd1) begin errors++; $display("FAIL mulhu_comb got %h exp %h", r0, 32'd1); end
        checks++; if (r1 !== 32'd1) begin errors++; $display("FAIL mulhu_iter got %h exp %h", r1, 32'd1); end
        md_op(MD_MUL, 2'b00, 32'hFFFF_FFFD, 32'd5, 32'd0, s0, s1, r0, r1, to);
        checks++; if (r0 !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mul_comb got %h exp %h", r0, 32'hFFFF_FFF1); end
        checks++; if (r1 !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mul_iter got %h exp %h", r1, 32'hFFFF_FFF1); end
        md_op(MD_MULHSU, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0, s0, s1, r0, r1, to);
        checks++; if (r0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_comb got %h exp %h", r0, 32'hFFFF_FFFF); end
        checks++; if (r1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_iter got %h exp %h", r1, 32'hFFFF_FFFF); end
    endtask

    task automatic test_flush();
        int s0, s1, seen; logic [31:0] r0, r1; bit to;
        @(posedge clk); #1;
        MdE = 1'b1; MdOpE = MD_DIV; ForwardAE = 2'b00; RD1E = 32'hFFFF_FFEC; RD2E = 32'd3;
        repeat (10) @(posedge clk);
        #1; FlushE = 1'b1; MdE = 1'b0;
        @(posedge clk); #1; FlushE = 1'b0;
        @(negedge clk);
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall0); end
        checks++; if (dut0.u_md.state !== IDLE) begin errors++; $display("FAIL flush_state got %0d exp IDLE", dut0.u_md.state); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dut0.u_md.done || stall0 || dut1.u_md.done || stall1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_result got %0d active cycles exp 0", seen); end
        md_op(MD_DIV, 2'b00, 32'hFFFF_FFEC, 32'd3, 32'd0, s0, s1, r0, r1, to);
        checks++; if (s0 !== 33 || r0 !== 32'hFFFF_FFFA) begin errors++; $display("FAIL flush_restart got %0d/%h exp 33/%h", s0, r0, 32'hFFFF_FFFA); end
    endtask

    task automatic test_reset_mid_run();
        int s0, s1; logic [31:0] r0, r1; bit to;
        @(posedge clk); #1;
        MdE = 1'b1; MdOpE = MD_DIV; ForwardAE = 2'b00; RD1E = 32'hFFFF_FFEC; RD2E = 32'd3;
        repeat (5) @(posedge clk);
        #2; reset = 1'b1; #1;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b exp 0", stall0); end
        checks++; if (dut1.u_md.state !== IDLE) begin errors++; $display("FAIL rst_mid_state got %0d exp IDLE", dut1.u_md.state); end
        MdE = 1'b0;
        @(negedge clk); reset = 1'b0;
        md_op(MD_REM, 2'b00, 32'hFFFF_FFEC, 32'd3, 32'd0, s0, s1, r0, r1, to);
        checks++; if (s1 !== 33 || r1 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rst_restart got %0d/%h exp 33/%h", s1, r1, 32'hFFFF_FFFE); end
    endtask

    task automatic test_forward_capture();
        int s0, s1; logic [31:0] r0, r1; bit to;
        md_op(MD_DIV, 2'b10, 32'd999, 32'd7, 32'd100, s0, s1, r0, r1, to);
        checks++; if (r0 !== 32'd14) begin errors++; $display("FAIL fwd_capture got %h exp %h", r0, 32'd14); end
        checks++; if (s0 !== 33) begin errors++; $display("FAIL fwd_stalls got %0d exp 33", s0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_div();
        test_div_special();
        test_mul();
        test_flush();
        test_reset_mid_run();
        test_forward_capture();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
